// File: rtl/set_multipass_ctrl_pkg.sv
// Shared state encodings and default geometry for the multipass SET controller.
package set_multipass_ctrl_pkg;

  localparam int unsigned DEF_SCAN_LEN = 17;
  localparam int unsigned DEF_CNT_W    = 5;
  localparam int unsigned DEF_PASS_W   = 2;

  typedef enum logic [1:0] {
    CTRL_IDLE  = 2'd0,
    CTRL_START = 2'd1,
    CTRL_BUSY  = 2'd2,
    CTRL_DONE  = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/set_scan_counter.sv
// Scan index counter: clear, increment, hold; saturates at SCAN_LEN-1 and flags it.
module set_scan_counter #(
  parameter int unsigned SCAN_LEN = 17,
  parameter int unsigned CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  // Terminal count marks the last accumulate cycle of a pass.
  assign tc = (cnt == CNT_W'(SCAN_LEN - 1));

  // Counter register; never wraps past the terminal value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !tc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/set_multipass_ctrl.sv
// Multipass SET controller: sequences passes of accumulate cycles with stall, abort and ack.
module set_multipass_ctrl
  import set_multipass_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_LEN = DEF_SCAN_LEN,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned PASS_W   = DEF_PASS_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [PASS_W-1:0] passes_i,
  input  logic              stall_i,
  input  logic              abort_i,
  input  logic              ack_i,
  output logic              valid_o,
  output logic              busy_o,
  output logic              acc_en_o,
  output logic              acc_clear_o,
  output logic              buffer_en_o,
  output logic              clear_o,
  output logic              coord_en_o,
  output logic [PASS_W-1:0] pass_o,
  output logic [CNT_W-1:0]  scan_o,
  output logic              last_o
);

  ctrl_state_t       state;
  ctrl_state_t       state_nxt;
  logic [PASS_W-1:0] pass;
  logic [PASS_W-1:0] pass_nxt;
  logic [PASS_W-1:0] pass_tot;
  logic [PASS_W-1:0] pass_tot_nxt;
  logic              scan_clr;
  logic              scan_inc;
  logic              scan_tc;
  logic [CNT_W-1:0]  scan;
  logic              final_pass;

  set_scan_counter #(
    .SCAN_LEN (SCAN_LEN),
    .CNT_W    (CNT_W)
  ) u_scan (
    .clk (clk_i),
    .rst (rst_i),
    .clr (scan_clr),
    .inc (scan_inc),
    .cnt (scan),
    .tc  (scan_tc)
  );

  assign final_pass = (pass == pass_tot);

  // State, pass index and job pass total registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= CTRL_IDLE;
      pass     <= '0;
      pass_tot <= '0;
    end else begin
      state    <= state_nxt;
      pass     <= pass_nxt;
      pass_tot <= pass_tot_nxt;
    end
  end

  // Next-state and counter control; abort overrides every transition.
  always_comb begin
    state_nxt    = state;
    pass_nxt     = pass;
    pass_tot_nxt = pass_tot;
    scan_clr     = 1'b0;
    scan_inc     = 1'b0;
    if (abort_i) begin
      state_nxt = CTRL_IDLE;
      pass_nxt  = '0;
      scan_clr  = 1'b1;
    end else begin
      case (state)
        CTRL_IDLE: begin
          if (en_i) begin
            state_nxt    = CTRL_START;
            pass_tot_nxt = passes_i;
            pass_nxt     = '0;
          end
        end
        CTRL_START: begin
          scan_clr  = 1'b1;
          state_nxt = CTRL_BUSY;
        end
        CTRL_BUSY: begin
          if (!stall_i) begin
            if (scan_tc) begin
              if (final_pass) begin
                state_nxt = CTRL_DONE;
              end else begin
                pass_nxt  = pass + PASS_W'(1);
                state_nxt = CTRL_START;
              end
            end else begin
              scan_inc = 1'b1;
            end
          end
        end
        CTRL_DONE: begin
          if (en_i) begin
            state_nxt    = CTRL_START;
            pass_tot_nxt = passes_i;
            pass_nxt     = '0;
          end else if (ack_i) begin
            state_nxt = CTRL_IDLE;
            pass_nxt  = '0;
            scan_clr  = 1'b1;
          end
        end
        default: state_nxt = CTRL_IDLE;
      endcase
    end
  end

  // Output decode: Moore from state, input-gated strobes for accumulate, last and buffer.
  always_comb begin
    valid_o     = (state == CTRL_DONE);
    clear_o     = (state == CTRL_DONE);
    busy_o      = (state == CTRL_START) || (state == CTRL_BUSY);
    coord_en_o  = (state == CTRL_START);
    acc_clear_o = (state == CTRL_START) && (pass == '0);
    acc_en_o    = (state == CTRL_BUSY) && !stall_i;
    last_o      = (state == CTRL_BUSY) && !stall_i && scan_tc && final_pass;
    buffer_en_o = en_i;
    pass_o      = pass;
    scan_o      = scan;
  end

endmodule

// File: tb/tb_set_multipass_ctrl.sv
// Directed self-checking bench for set_multipass_ctrl with SCAN_LEN=17.
module tb_set_multipass_ctrl;

  localparam int unsigned SCAN_LEN = 17;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned PASS_W   = 2;

  logic              clk_i;
  logic              rst_i;
  logic              en_i;
  logic [PASS_W-1:0] passes_i;
  logic              stall_i;
  logic              abort_i;
  logic              ack_i;
  logic              valid_o;
  logic              busy_o;
  logic              acc_en_o;
  logic              acc_clear_o;
  logic              buffer_en_o;
  logic              clear_o;
  logic              coord_en_o;
  logic [PASS_W-1:0] pass_o;
  logic [CNT_W-1:0]  scan_o;
  logic              last_o;

  int checks;
  int errors;

  int n_busy, n_acc, n_clr, n_coord, n_last, cyc, frozen_bad, stall_hits;
  int coord_cyc [4];
  int coord_pass [4];
  int cnt;
  bit found;

  set_multipass_ctrl #(
    .SCAN_LEN (SCAN_LEN),
    .CNT_W    (CNT_W),
    .PASS_W   (PASS_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .passes_i    (passes_i),
    .stall_i     (stall_i),
    .abort_i     (abort_i),
    .ack_i       (ack_i),
    .valid_o     (valid_o),
    .busy_o      (busy_o),
    .acc_en_o    (acc_en_o),
    .acc_clear_o (acc_clear_o),
    .buffer_en_o (buffer_en_o),
    .clear_o     (clear_o),
    .coord_en_o  (coord_en_o),
    .pass_o      (pass_o),
    .scan_o      (scan_o),
    .last_o      (last_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Pulse en_i for one cycle; returns in the START cycle.
  task automatic start_job(input logic [PASS_W-1:0] p);
    en_i     = 1'b1;
    passes_i = p;
    tick();
    en_i = 1'b0;
  endtask

  // Count strobes from the current START cycle until valid_o, optionally stalling once.
  task automatic run_job(input int stall_at, input int stall_len);
    int  remaining;
    bit  stalled;
    n_busy = 0; n_acc = 0; n_clr = 0; n_coord = 0; n_last = 0;
    cyc = 0; frozen_bad = 0; stall_hits = 0; remaining = 0; stalled = 1'b0;
    while (cyc < 500) begin
      if (stall_at >= 0 && !stalled && busy_o && !coord_en_o && int'(scan_o) == stall_at) begin
        stalled   = 1'b1;
        stall_i   = 1'b1;
        remaining = stall_len;
      end
      #1;
      if (valid_o) break;
      if (busy_o) n_busy++;
      if (acc_en_o) n_acc++;
      if (acc_clear_o) n_clr++;
      if (last_o) n_last++;
      if (coord_en_o) begin
        if (n_coord < 4) begin
          coord_cyc[n_coord]  = cyc;
          coord_pass[n_coord] = int'(pass_o);
        end
        n_coord++;
      end
      if (stall_i) begin
        stall_hits++;
        if (acc_en_o || int'(scan_o) != stall_at) frozen_bad++;
      end
      tick();
      if (stall_i) begin
        remaining--;
        if (remaining == 0) stall_i = 1'b0;
      end
      cyc++;
    end
    chk("job_reaches_valid", valid_o, 1);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_i = 1'b1; en_i = 1'b0; passes_i = '0; stall_i = 1'b0; abort_i = 1'b0; ack_i = 1'b0;
    #2;
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_scan", scan_o, 0);
    chk("rst_pass", pass_o, 0);
    chk("rst_coord", coord_en_o, 0);
    en_i = 1'b1;
    #1;
    chk("rst_buffer_en_follows", buffer_en_o, 1);
    en_i = 1'b0;
    #10;
    rst_i = 1'b0;
    tick();
    chk("idle_busy", busy_o, 0);

    // Single pass job.
    start_job(2'd0);
    #1;
    chk("p0_start_clear", acc_clear_o, 1);
    run_job(-1, 0);
    chk("p0_latency", cyc, 18);
    chk("p0_busy_cycles", n_busy, 18);
    chk("p0_acc_cycles", n_acc, 17);
    chk("p0_clear_pulses", n_clr, 1);
    chk("p0_last_pulses", n_last, 1);
    chk("p0_clear_o", clear_o, 1);
    tick();
    chk("p0_valid_held", valid_o, 1);
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    #1;
    chk("ack_valid_drop", valid_o, 0);
    chk("ack_idle_busy", busy_o, 0);
    chk("ack_idle_scan", scan_o, 0);

    // Three pass job.
    start_job(2'd2);
    run_job(-1, 0);
    chk("p2_latency", cyc, 54);
    chk("p2_coord_pulses", n_coord, 3);
    chk("p2_coord_gap0", coord_cyc[1] - coord_cyc[0], 18);
    chk("p2_coord_gap1", coord_cyc[2] - coord_cyc[1], 18);
    chk("p2_pass_idx0", coord_pass[0], 0);
    chk("p2_pass_idx1", coord_pass[1], 1);
    chk("p2_pass_idx2", coord_pass[2], 2);
    chk("p2_clear_pulses", n_clr, 1);
    chk("p2_last_pulses", n_last, 1);
    chk("p2_acc_cycles", n_acc, 51);
    chk("p2_done_pass", pass_o, 2);

    // en_i and ack_i together in DONE restart with new pass count.
    en_i = 1'b1; ack_i = 1'b1; passes_i = 2'd1;
    tick();
    en_i = 1'b0; ack_i = 1'b0;
    #1;
    chk("restart_coord", coord_en_o, 1);
    chk("restart_clear", acc_clear_o, 1);
    chk("restart_valid", valid_o, 0);
    chk("restart_pass", pass_o, 0);
    run_job(-1, 0);
    chk("p1_latency", cyc, 36);

    // Neither en_i nor ack_i: DONE holds.
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (valid_o) cnt++;
    end
    chk("done_hold_cycles", cnt, 12);
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;

    // Stall five cycles at scan 6.
    start_job(2'd0);
    run_job(6, 5);
    chk("stall_latency", cyc, 23);
    chk("stall_cycles", stall_hits, 5);
    chk("stall_frozen", frozen_bad, 0);
    chk("stall_acc_cycles", n_acc, 17);
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;

    // Abort at pass 1, scan 8.
    start_job(2'd3);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy_o && !coord_en_o && pass_o == 2'd1 && scan_o == 5'd8) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("abort_point_found", found, 1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    #1;
    chk("abort_busy", busy_o, 0);
    chk("abort_valid", valid_o, 0);
    chk("abort_pass", pass_o, 0);
    chk("abort_scan", scan_o, 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid_o) cnt++;
    end
    chk("abort_no_valid", cnt, 0);
    start_job(2'd0);
    #1;
    chk("post_abort_clear", acc_clear_o, 1);
    chk("post_abort_pass", pass_o, 0);
    run_job(-1, 0);
    chk("post_abort_latency", cyc, 18);
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;

    // Abort together with en_i in IDLE stays IDLE.
    abort_i = 1'b1; en_i = 1'b1;
    tick();
    abort_i = 1'b0; en_i = 1'b0;
    #1;
    chk("abort_en_idle", busy_o, 0);

    // Asynchronous reset in the middle of BUSY.
    start_job(2'd1);
    for (int i = 0; i < 10; i++) tick();
    #3;
    rst_i = 1'b1; en_i = 1'b1;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_acc_en", acc_en_o, 0);
    chk("arst_scan", scan_o, 0);
    chk("arst_pass", pass_o, 0);
    chk("arst_valid", valid_o, 0);
    chk("arst_buffer_en", buffer_en_o, 1);
    en_i = 1'b0;
    #1;
    rst_i = 1'b0;
    tick();
    chk("arst_after_idle", busy_o, 0);
    start_job(2'd0);
    run_job(-1, 0);
    chk("arst_job_latency", cyc, 18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
